// File: rtl/rounding_pkg.sv
// Shared width relations for the sample_accumulator -> rounding_division path.
// Block length is N = 2**div_log2; a block sum needs div_log2 extra bits.
package rounding_pkg;

  localparam int DEF_DIV_LOG2  = 3;
  localparam int DEF_OUT_WIDTH = 32;

  function automatic int sum_width(input int out_width, input int div_log2);
    return out_width + div_log2;
  endfunction

  // A count must hold N itself, not just N-1.
  function automatic int count_width(input int div_log2);
    return div_log2 + 1;
  endfunction

  typedef logic [count_width(DEF_DIV_LOG2)-1:0] blk_count_t;

endpackage

// File: rtl/sample_accumulator_if.sv
// Sample stream in, block-sum stream out. Both sides use valid/ready: a transfer
// happens on a rising clock edge where valid and ready are both high; valid
// holds its payload stable until that edge, and ready never depends on valid.
interface sample_accumulator_if #(
  parameter int DIV_LOG2  = 3,
  parameter int OUT_WIDTH = 32,
  parameter int IN_WIDTH  = 35
);
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] in_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [IN_WIDTH-1:0]  out_sum;
  logic [DIV_LOG2:0]    out_count;
  logic                 out_partial;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_partial
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_partial
  );
endinterface

// File: rtl/sample_accumulator_outreg.sv
// Single-entry output holding register: load when free or draining, hold while
// stalled. The caller only raises load when the register can take new data.
module sample_accumulator_outreg #(
  parameter int SW = 35,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic [SW-1:0] load_sum,
  input  logic [CW-1:0] load_count,
  input  logic          load_partial,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [SW-1:0] out_sum,
  output logic [CW-1:0] out_count,
  output logic          out_partial
);

  logic          valid_q, valid_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [CW-1:0] count_q, count_d;
  logic          partial_q, partial_d;

  always_comb begin
    valid_d   = valid_q;
    sum_d     = sum_q;
    count_d   = count_q;
    partial_d = partial_q;
    if (load) begin
      valid_d   = 1'b1;
      sum_d     = load_sum;
      count_d   = load_count;
      partial_d = load_partial;
    end else if (out_ready) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      sum_q     <= '0;
      count_q   <= '0;
      partial_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      partial_q <= partial_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_sum     = sum_q;
  assign out_count   = count_q;
  assign out_partial = partial_q;

endmodule

// File: rtl/sample_accumulator.sv
// Sums every 2**DIV_LOG2 unsigned samples into one wide total; flush emits the
// current partial block. Accumulate/flush control here, output register below.
module sample_accumulator
  import rounding_pkg::*;
#(
  parameter int DIV_LOG2  = DEF_DIV_LOG2,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int IN_WIDTH  = sum_width(OUT_WIDTH, DIV_LOG2)
) (
  input logic                  clk,
  input logic                  resetn,
  sample_accumulator_if.slave  io
);

  localparam int                    CW         = count_width(DIV_LOG2);
  localparam logic [DIV_LOG2-1:0]   CNT_LAST   = '1;
  localparam logic [CW-1:0]         FULL_COUNT = CW'(1 << DIV_LOG2);

  if (IN_WIDTH != sum_width(OUT_WIDTH, DIV_LOG2)) begin : g_bad_width
    $error("sample_accumulator: IN_WIDTH must equal OUT_WIDTH + DIV_LOG2");
  end
  if (DIV_LOG2 < 1 || DIV_LOG2 > 8) begin : g_bad_div
    $error("sample_accumulator: DIV_LOG2 must be in 1..8");
  end

  logic [IN_WIDTH-1:0] acc_q, acc_d;
  logic [DIV_LOG2-1:0] cnt_q, cnt_d;
  logic                flush_pend_q, flush_pend_d;

  logic                accept;
  logic                completing;
  logic                flush_req;
  logic                has_data;
  logic                out_free;
  logic [IN_WIDTH-1:0] sum_now;
  logic [CW-1:0]       cnt_now;
  logic                load;
  logic [CW-1:0]       load_count;
  logic                load_partial;

  // Stall only when a completing sample would find the output still occupied.
  assign io.in_ready = resetn & ~flush_pend_q & ~(io.out_valid & (cnt_q == CNT_LAST));

  assign accept     = io.in_valid & io.in_ready;
  assign sum_now    = acc_q + (accept ? IN_WIDTH'(io.in_data) : '0);
  assign cnt_now    = CW'(cnt_q) + CW'(accept);
  assign completing = accept & (cnt_q == CNT_LAST);
  assign flush_req  = io.flush | flush_pend_q;
  assign has_data   = (cnt_q != '0) | accept;
  assign out_free   = ~io.out_valid | io.out_ready;

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    load         = 1'b0;
    load_count   = FULL_COUNT;
    load_partial = 1'b0;
    if (completing) begin
      // A full block swallows any flush raised in the same cycle.
      load         = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else if (flush_req && has_data) begin
      if (out_free) begin
        load         = 1'b1;
        load_count   = cnt_now;
        load_partial = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
        if (accept) begin
          acc_d = sum_now;
          cnt_d = cnt_q + DIV_LOG2'(1);
        end
      end
    end else if (accept) begin
      acc_d = sum_now;
      cnt_d = cnt_q + DIV_LOG2'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  sample_accumulator_outreg #(
    .SW (IN_WIDTH),
    .CW (CW)
  ) u_outreg (
    .clk          (clk),
    .resetn       (resetn),
    .load         (load),
    .load_sum     (sum_now),
    .load_count   (load_count),
    .load_partial (load_partial),
    .out_ready    (io.out_ready),
    .out_valid    (io.out_valid),
    .out_sum      (io.out_sum),
    .out_count    (io.out_count),
    .out_partial  (io.out_partial)
  );

endmodule

// File: doc/sample_accumulator.md
# sample_accumulator

Streaming block accumulator that produces the wide dividend consumed by the `rounding_division` stage. It sums every 2^DIV_LOG2 unsigned OUT_WIDTH-bit samples into one IN_WIDTH-bit total and presents it through a registered valid/ready output. Downstream, `rounding_division` turns that total back into a rounded OUT_WIDTH-bit average. A flush input emits partial blocks at end of stream.

## Interface
- DIV_LOG2, 3, log2 of block length N = 2^DIV_LOG2; legal range 1..8
- OUT_WIDTH, 32, sample width (unsigned)
- IN_WIDTH, OUT_WIDTH+DIV_LOG2, sum width; must equal OUT_WIDTH+DIV_LOG2 (elaboration error otherwise)
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  block accepts sample
- in_data  in  OUT_WIDTH  sample value
- flush  in  1  single-cycle request to emit the current partial block
- out_valid  out  1  sum available
- out_ready  in  1  downstream takes sum
- out_sum  out  IN_WIDTH  block sum
- out_count  out  DIV_LOG2+1  samples in out_sum (N for a full block)
- out_partial  out  1  1 = emitted by flush, 0 = full block

## Operation
- State: acc (IN_WIDTH), cnt (0..N-1), output register {out_sum, out_count, out_partial, out_valid}, flush_pend.
- Accept = in_valid & in_ready. On accept: acc += in_data, cnt += 1.
- Completion: an accept with cnt == N-1 loads the output register with acc+in_data, count N, partial 0. acc and cnt clear.
- No overflow is possible: N*(2^OUT_WIDTH-1) < 2^IN_WIDTH. No saturation logic.
- Flush: if cnt > 0 or a sample is accepted that cycle, emit acc (including that sample) with count = cnt(+1) and partial 1. acc and cnt clear.
  - With cnt == 0 and no accept, flush is ignored.
  - If the accepting sample completes a block, a full block (partial 0) is emitted and the flush is consumed.
- Output register busy (out_valid & ~out_ready) when an emit is required:
  - A flush sets flush_pend.
  - Completion cannot occur, because in_ready is already low.
- in_ready = resetn & ~flush_pend & ~(out_valid & cnt == N-1). There is no combinational path from out_ready or in_valid.
- flush_pend emits on the first cycle the output register is free or draining, then clears.
- Output register holds all fields stable while out_valid & ~out_ready. It reloads in the same cycle it drains (out_ready & out_valid) when a new emit is due.

## Timing
- Reset values: out_valid 0, out_sum 0, out_count 0, out_partial 0, in_ready 0 while resetn low, acc 0, cnt 0, flush_pend 0.
- in_ready is 1 in the first cycle after reset release.
- Latency: out_valid rises on the clock edge that accepts the N-th sample (registered). Data is visible the following cycle.
- Throughput: one sample per cycle sustained while out_ready is high. Back-to-back blocks produce no bubble.
- With out_ready low, up to N-1 samples of the next block are absorbed before stall.
- Reset mid-block or with out_valid high: the pending sum and the partial block are discarded, with no output.

## Structure
- Shared package `rounding_pkg`:
  - the DIV_LOG2/OUT_WIDTH/IN_WIDTH width relation
  - a `blk_count_t` width helper, shared with `rounding_division` and its bench
- One natural sub-module: `sample_accumulator_outreg`, the single-entry valid/ready output holding register with load/drain. The accumulate/flush control lives in the top module.

## Test plan
All scenarios use DIV_LOG2=3, OUT_WIDTH=32, out_ready=1 unless stated.
- 8 samples of 8 back-to-back -> one cycle with out_valid, out_sum=64, out_count=8, out_partial=0. Feeding that to `rounding_division` gives 8.
- Samples 8,8,8,8,8,8,8,12 -> out_sum=68, count 8. Via the divider -> 9.
- 8 samples of 0xFFFF_FFFF -> out_sum=0x7_FFFF_FFF8, no wrap.
- out_ready=0, 16 samples offered continuously:
  - first sum 64 held stable
  - in_ready drops after 7 samples of block 2
  - after out_ready=1, 64 drains, then the second sum (64) follows with no sample lost.
- Flush cases:
  - 3 samples of 5 then flush -> out_sum=15, out_count=3, out_partial=1.
  - Flush with cnt=0 -> no output.
  - Flush while the output is stalled -> in_ready low until the partial is emitted.
- Reset (resetn low for 1 cycle) after 5 samples and with a pending sum -> all outputs 0, nothing emitted. Then 8 samples of 1 -> out_sum=8.
